// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Feeds the keyboard controller's KEY_STB/KEY_OP port. Single-key press/release
//   events are queued in a small FIFO. Shadow copies of the 8 matrix rows and the
//   modifier byte are kept, and each change is sent as a full-byte write op.
//   After reset or CLEAR all 9 bytes are re-sent (rows 0..7, then modifier).
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   EV_VALID/EV_READY   event handshake; EV_PRESS, EV_MOD, EV_ROW, EV_COL carry the event
//   CLEAR               1-cycle pulse: release all keys, flush the FIFO, re-sync
//   KEY_STB, KEY_OP     1-cycle op strobe and op word {sel, row[2:0], data[7:0]}
//   KEY_BUSY            controller busy; no strobe is issued while high
//   DBG_STATE           current FSM state (SYNC=0 IDLE=1 APPLY=2 ISSUE=3 GAP=4)
// Handshake: an event is taken on a rising CLK edge where EV_VALID && EV_READY and
//   CLEAR is low; the offer may be held or withdrawn freely while EV_READY is low.
module key_event_encoder #(
   parameter int DEPTH      = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        EV_VALID,
   output logic        EV_READY,
   input  logic        EV_PRESS,
   input  logic        EV_MOD,
   input  logic [2:0]  EV_ROW,
   input  logic [2:0]  EV_COL,
   input  logic        CLEAR,
   output logic        KEY_STB,
   output logic [11:0] KEY_OP,
   input  logic        KEY_BUSY,
   output logic [2:0]  DBG_STATE
);
   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic       REL      = ACTIVE_LOW;
   localparam logic [7:0] REL_BYTE = {8{REL}};

   typedef enum logic [2:0] {
      S_SYNC  = 3'd0,
      S_IDLE  = 3'd1,
      S_APPLY = 3'd2,
      S_ISSUE = 3'd3,
      S_GAP   = 3'd4
   } state_e;

   typedef struct packed {
      logic       press;
      logic       mod;
      logic [2:0] row;
      logic [2:0] col;
   } ev_t;

   state_e         state_q, state_d;
   ev_t            fifo_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    count_q;
   logic           full, empty, push, pop;
   ev_t            head, ev_in;

   logic [7:0]     rows_q [8];
   logic [7:0]     mod_q;
   logic [3:0]     idx_q, idx_d;
   logic           sync_pend_q, sync_pend_d;
   logic [11:0]    op_q, op_d;
   logic           shadow_we;
   logic [7:0]     old_byte, new_byte;

   // ---------------- event FIFO ----------------
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign ev_in = '{press: EV_PRESS, mod: EV_MOD, row: EV_ROW, col: EV_COL};
   assign head  = fifo_q[rd_ptr_q];
   assign push  = EV_VALID && EV_READY && !CLEAR;
   assign pop   = (state_q == S_APPLY) && !empty && !CLEAR;

   always_ff @(posedge CLK) begin
      if (push) fifo_q[wr_ptr_q] <= ev_in;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (CLEAR) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + (AW+1)'(1);
         else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      end
   end

   // ---------------- shadows ----------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int r = 0; r < 8; r++) rows_q[r] <= REL_BYTE;
         mod_q <= REL_BYTE;
      end else if (CLEAR) begin
         for (int r = 0; r < 8; r++) rows_q[r] <= REL_BYTE;
         mod_q <= REL_BYTE;
      end else if (shadow_we) begin
         if (head.mod) mod_q <= new_byte;
         else          rows_q[head.row] <= new_byte;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= S_SYNC;
         idx_q       <= '0;
         sync_pend_q <= 1'b1;
         op_q        <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sync_pend_q <= sync_pend_d;
         op_q        <= op_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sync_pend_d = sync_pend_q;
      op_d        = op_q;
      shadow_we   = 1'b0;
      old_byte    = head.mod ? mod_q : rows_q[head.row];
      new_byte    = old_byte;
      new_byte[head.col] = head.press ? ~REL : REL;

      case (state_q)
         S_SYNC: begin
            // idx 0..7 sends a row, idx 8 sends the modifier byte
            op_d    = idx_q[3] ? {1'b1, 3'b000, mod_q}
                               : {1'b0, idx_q[2:0], rows_q[idx_q[2:0]]};
            idx_d   = idx_q + 4'd1;
            state_d = S_ISSUE;
         end
         S_IDLE: begin
            // Looking at the incoming push saves a cycle on an empty FIFO
            if (!empty || push) state_d = S_APPLY;
         end
         S_APPLY: begin
            if (new_byte != old_byte) begin
               shadow_we = 1'b1;
               op_d      = {head.mod, (head.mod ? 3'b000 : head.row), new_byte};
               state_d   = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (!KEY_BUSY) begin
               state_d = S_GAP;
               // Re-sync is over once the modifier op (idx was 8, now 9) has gone out
               if (sync_pend_q && idx_q == 4'd9) sync_pend_d = 1'b0;
            end
         end
         S_GAP: begin
            if (sync_pend_q)  state_d = S_SYNC;
            else if (!empty)  state_d = S_APPLY;
            else              state_d = S_IDLE;
         end
         default: state_d = S_SYNC;
      endcase

      // CLEAR overrides everything; a strobe issued this cycle still stands
      if (CLEAR) begin
         state_d     = S_SYNC;
         idx_d       = '0;
         sync_pend_d = 1'b1;
         shadow_we   = 1'b0;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      KEY_STB   = (state_q == S_ISSUE) && !KEY_BUSY;
      EV_READY  = !full && !sync_pend_q;
      KEY_OP    = op_q;
      DBG_STATE = state_q;
   end
endmodule

// File: tb/tb_key_event_encoder.sv
module tb_key_event_encoder;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        EV_VALID, EV_PRESS, EV_MOD, CLEAR, KEY_BUSY;
   logic [2:0]  EV_ROW, EV_COL;
   logic        EV_READY, KEY_STB;
   logic [11:0] KEY_OP;
   logic [2:0]  DBG_STATE;

   int tests = 0;
   int fails = 0;

   key_event_encoder #(.DEPTH(8), .ACTIVE_LOW(1'b1)) dut (
      .CLK(CLK), .RESET(RESET), .EV_VALID(EV_VALID), .EV_READY(EV_READY),
      .EV_PRESS(EV_PRESS), .EV_MOD(EV_MOD), .EV_ROW(EV_ROW), .EV_COL(EV_COL),
      .CLEAR(CLEAR), .KEY_STB(KEY_STB), .KEY_OP(KEY_OP), .KEY_BUSY(KEY_BUSY),
      .DBG_STATE(DBG_STATE)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   typedef struct {
      logic        press;
      logic        mod;
      logic [2:0]  row;
      logic [2:0]  col;
      logic [11:0] exp_op;
      bit          exp_stb;
   } vec_t;

   vec_t vecs[12];
   vec_t t4[9];

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Called just after a rising edge; returns just after the edge that took the event.
   task automatic push_ev(input logic press, input logic mod, input logic [2:0] row,
                          input logic [2:0] col);
      int n = 0;
      EV_PRESS = press; EV_MOD = mod; EV_ROW = row; EV_COL = col;
      EV_VALID = 1'b1;
      @(negedge CLK);
      while (!EV_READY && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!EV_READY) begin
         tests++; fails++;
         $display("FAIL push_wait: EV_READY still 0 after 50 cycles, expected 1");
      end
      @(posedge CLK);
      #1;
      EV_VALID = 1'b0;
   endtask

   // Waits (bounded) for a strobe; lat = number of falling edges until it is seen.
   task automatic expect_op(input string name, input logic [11:0] exp, output int lat);
      lat = 0;
      while (lat < 40) begin
         @(negedge CLK);
         lat++;
         if (KEY_STB) break;
      end
      if (!KEY_STB) begin
         tests++; fails++;
         $display("FAIL %s: no KEY_STB within 40 cycles, expected op 0x%03h", name, exp);
      end else begin
         check(name, KEY_OP, exp);
      end
   endtask

   task automatic expect_none(input string name, input int cycles);
      logic seen = 1'b0;
      repeat (cycles) begin
         @(negedge CLK);
         if (KEY_STB) seen = 1'b1;
      end
      check(name, seen, 1'b0);
   endtask

   // Full 9-op re-sync with all keys released, back-to-back (3 cycles apart).
   task automatic sync_seq(input string pfx);
      int lat;
      logic [2:0] r;
      for (int i = 0; i < 9; i++) begin
         r = 3'(i);
         expect_op($sformatf("%s_sync%0d", pfx, i),
                   (i < 8) ? {1'b0, r, 8'hFF} : 12'h8FF, lat);
         if (i > 0) check($sformatf("%s_sync%0d_spacing", pfx, i), lat, 3);
      end
      check({pfx, "_ready_at_last_sync"}, EV_READY, 1'b0);
      @(negedge CLK);
      check({pfx, "_ready_after_sync"}, EV_READY, 1'b1);
   endtask

   // ---------------- stimulus + scoreboard ----------------
   initial begin
      int lat;
      RESET = 1'b1; EV_VALID = 1'b0; EV_PRESS = 1'b0; EV_MOD = 1'b0;
      EV_ROW = '0; EV_COL = '0; CLEAR = 1'b0; KEY_BUSY = 1'b0;

      // Single-event vectors (ACTIVE_LOW: pressed bit = 0)
      //            press mod row   col   op      strobe
      vecs[0]  = '{1'b1, 1'b0, 3'd3, 3'd5, 12'h3DF, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 3'd3, 3'd5, 12'h3FF, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 3'd3, 3'd5, 12'h3DF, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 3'd3, 3'd5, 12'h000, 1'b0};  // duplicate press
      vecs[4]  = '{1'b0, 1'b0, 3'd3, 3'd5, 12'h3FF, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 3'd0, 3'd0, 12'h8FE, 1'b1};  // modifier press col 0
      vecs[6]  = '{1'b1, 1'b0, 3'd3, 3'd5, 12'h3DF, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 3'd0, 3'd7, 12'h07F, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 3'd0, 3'd0, 12'h8FF, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 3'd7, 3'd0, 12'h7FE, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 3'd5, 3'd7, 12'h87F, 1'b1};  // row ignored for modifier
      vecs[11] = '{0,    1'b0, 3'd3, 3'd5, 12'h3FF, 1'b1};

      // Row 1 filled bit by bit, then bit 0 released again
      t4[0] = '{1'b1, 1'b0, 3'd1, 3'd0, 12'h1FE, 1'b1};
      t4[1] = '{1'b1, 1'b0, 3'd1, 3'd1, 12'h1FC, 1'b1};
      t4[2] = '{1'b1, 1'b0, 3'd1, 3'd2, 12'h1F8, 1'b1};
      t4[3] = '{1'b1, 1'b0, 3'd1, 3'd3, 12'h1F0, 1'b1};
      t4[4] = '{1'b1, 1'b0, 3'd1, 3'd4, 12'h1E0, 1'b1};
      t4[5] = '{1'b1, 1'b0, 3'd1, 3'd5, 12'h1C0, 1'b1};
      t4[6] = '{1'b1, 1'b0, 3'd1, 3'd6, 12'h180, 1'b1};
      t4[7] = '{1'b1, 1'b0, 3'd1, 3'd7, 12'h100, 1'b1};
      t4[8] = '{1'b0, 1'b0, 3'd1, 3'd0, 12'h101, 1'b1};

      // ---- Test 1: reset state, then power-up sync ----
      repeat (3) @(posedge CLK);
      #1;
      check("rst_key_stb", KEY_STB, 1'b0);
      check("rst_key_op", KEY_OP, 12'h000);
      check("rst_ev_ready", EV_READY, 1'b0);
      check("rst_state_sync", DBG_STATE, 3'd0);
      RESET = 1'b0;
      sync_seq("t1");

      // ---- Tests 2/3: single events from an idle, empty FIFO ----
      for (int i = 0; i < 12; i++) begin
         repeat (3) step();
         push_ev(vecs[i].press, vecs[i].mod, vecs[i].row, vecs[i].col);
         if (vecs[i].exp_stb) begin
            expect_op($sformatf("vec%0d_op", i), vecs[i].exp_op, lat);
            check($sformatf("vec%0d_latency", i), lat, 2);
         end else begin
            expect_none($sformatf("vec%0d_no_op", i), 8);
         end
      end

      // ---- Test 4: busy controller, FIFO fills, ops drain in order ----
      repeat (3) step();
      KEY_BUSY = 1'b1;
      for (int i = 0; i < 9; i++) push_ev(t4[i].press, t4[i].mod, t4[i].row, t4[i].col);
      @(negedge CLK);
      check("t4_fifo_full_ready", EV_READY, 1'b0);
      check("t4_op_held", KEY_OP, 12'h1FE);
      expect_none("t4_no_stb_while_busy", 6);
      step();
      KEY_BUSY = 1'b0;
      for (int i = 0; i < 9; i++) begin
         expect_op($sformatf("t4_op%0d", i), t4[i].exp_op, lat);
         if (i > 0) check($sformatf("t4_op%0d_spacing", i), lat, 3);
      end
      @(negedge CLK);
      check("t4_ready_after_drain", EV_READY, 1'b1);

      // ---- Test 5: CLEAR while an op waits in ISSUE ----
      repeat (3) step();
      KEY_BUSY = 1'b1;
      push_ev(1'b1, 1'b0, 3'd2, 3'd1);
      push_ev(1'b1, 1'b0, 3'd4, 3'd4);
      step();
      @(negedge CLK);
      check("t5_pending_op", KEY_OP, 12'h2FD);
      check("t5_no_stb_busy", KEY_STB, 1'b0);
      step();
      // An event offered in the CLEAR cycle must be dropped
      CLEAR = 1'b1;
      EV_VALID = 1'b1; EV_PRESS = 1'b1; EV_MOD = 1'b0; EV_ROW = 3'd5; EV_COL = 3'd3;
      step();
      CLEAR = 1'b0;
      EV_VALID = 1'b0;
      @(negedge CLK);
      check("t5_state_sync", DBG_STATE, 3'd0);
      check("t5_ready_in_sync", EV_READY, 1'b0);
      step();
      KEY_BUSY = 1'b0;
      sync_seq("t5");
      expect_none("t5_fifo_flushed", 8);
      // Shadows were released: these presses now change bytes again
      repeat (3) step();
      push_ev(1'b1, 1'b0, 3'd2, 3'd1);
      expect_op("t5_row2_after_clear", 12'h2FD, lat);
      repeat (3) step();
      push_ev(1'b1, 1'b0, 3'd1, 3'd0);
      expect_op("t5_row1_after_clear", 12'h1FE, lat);
      repeat (3) step();
      push_ev(1'b1, 1'b1, 3'd0, 3'd7);
      expect_op("t5_mod_after_clear", 12'h87F, lat);

      // ---- Test 6: RESET during ISSUE drops the strobe at once ----
      repeat (3) step();
      KEY_BUSY = 1'b1;
      push_ev(1'b1, 1'b0, 3'd6, 3'd2);
      step();
      KEY_BUSY = 1'b0;
      #1;
      check("t6_stb_before_reset", KEY_STB, 1'b1);
      check("t6_op_before_reset", KEY_OP, 12'h6FB);
      RESET = 1'b1;
      #1;
      check("t6_stb_drop", KEY_STB, 1'b0);
      check("t6_op_cleared", KEY_OP, 12'h000);
      check("t6_ready_low", EV_READY, 1'b0);
      step();
      RESET = 1'b0;
      sync_seq("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time limit so the bench can never hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units, expected completion");
      $fatal(1, "timeout");
   end
endmodule
